// File: rtl/servo_pulse_meter_if.sv
// Servo pulse meter bus: PWM input plus the measured width/period/status outputs.
// Latency: none (wires only).
// Backpressure: none; the result strobe is fire-and-forget.
interface servo_pulse_meter_if;
  logic        pwm_in;
  logic [19:0] pulse_width;
  logic [19:0] period;
  logic        valid;
  logic        range_err;
  logic        no_signal;

  // Stimulus / consumer side
  modport master (
    output pwm_in,
    input  pulse_width, period, valid, range_err, no_signal
  );

  // Meter side
  modport slave (
    input  pwm_in,
    output pulse_width, period, valid, range_err, no_signal
  );
endinterface

// File: rtl/servo_pulse_meter.sv
// Measures servo PWM high time and rise-to-rise period in clock cycles, with range and loss-of-signal flags.
// Latency: pin edge to internal edge is 3 cycles; results publish on the rise that closes each full frame.
// Backpressure: none; valid is a one-cycle strobe and results hold until the next strobe.
module servo_pulse_meter #(
  parameter int MIN_WIDTH      = 25000,
  parameter int MAX_WIDTH      = 125000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input logic                clk,
  input logic                rst,
  servo_pulse_meter_if.slave bus
);

  typedef enum logic [1:0] {S_ARM, S_WAIT_RISE, S_HIGH, S_LOW} state_t;

  localparam logic [19:0] MIN_W   = 20'(MIN_WIDTH);
  localparam logic [19:0] MAX_W   = 20'(MAX_WIDTH);
  localparam logic [20:0] TO_LAST = 21'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        edge_q, edge_d;
  logic [1:0]  fill_q, fill_d;
  logic [19:0] hi_cnt_q, hi_cnt_d;
  logic [19:0] per_cnt_q, per_cnt_d;
  logic [20:0] to_cnt_q, to_cnt_d;
  logic [19:0] pulse_width_q, pulse_width_d;
  logic [19:0] period_q, period_d;
  logic        valid_q, valid_d;
  logic        range_err_q, range_err_d;
  logic        no_signal_q, no_signal_d;

  logic s, rise, fall, timeout;

  function automatic logic [19:0] sat_inc(input logic [19:0] v);
    return (v == 20'hFFFFF) ? v : v + 20'd1;
  endfunction

  // State and datapath registers; everything returns to zero / S_ARM on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_ARM;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      edge_q        <= 1'b0;
      fill_q        <= 2'b00;
      hi_cnt_q      <= '0;
      per_cnt_q     <= '0;
      to_cnt_q      <= '0;
      pulse_width_q <= '0;
      period_q      <= '0;
      valid_q       <= 1'b0;
      range_err_q   <= 1'b0;
      no_signal_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      edge_q        <= edge_d;
      fill_q        <= fill_d;
      hi_cnt_q      <= hi_cnt_d;
      per_cnt_q     <= per_cnt_d;
      to_cnt_q      <= to_cnt_d;
      pulse_width_q <= pulse_width_d;
      period_q      <= period_d;
      valid_q       <= valid_d;
      range_err_q   <= range_err_d;
      no_signal_q   <= no_signal_d;
    end
  end

  // Synchronizer, edge detect, measurement FSM and timeout watchdog
  always_comb begin
    sync1_d       = bus.pwm_in;
    sync2_d       = sync1_q;
    edge_d        = sync2_q;
    // fill_q[1] marks that s now reflects a pin sample taken after reset,
    // so S_ARM cannot mistake the reset value of the synchronizer for a low.
    fill_d        = {fill_q[0], 1'b1};
    state_d       = state_q;
    hi_cnt_d      = hi_cnt_q;
    per_cnt_d     = per_cnt_q;
    to_cnt_d      = to_cnt_q + 21'd1;
    pulse_width_d = pulse_width_q;
    period_d      = period_q;
    valid_d       = 1'b0;
    range_err_d   = range_err_q;
    no_signal_d   = no_signal_q;

    s       = sync2_q;
    rise    = s & ~edge_q;
    fall    = ~s & edge_q;
    timeout = ~(rise | fall) & (to_cnt_q == TO_LAST);

    if (rise | fall) begin
      to_cnt_d = '0;
    end

    case (state_q)
      S_ARM: begin
        if (fill_q[1] && !s) begin
          state_d = S_WAIT_RISE;
        end
      end
      S_WAIT_RISE: begin
        if (rise) begin
          state_d   = S_HIGH;
          hi_cnt_d  = 20'd1;
          per_cnt_d = 20'd1;
        end
      end
      S_HIGH: begin
        per_cnt_d = sat_inc(per_cnt_q);
        if (fall) begin
          state_d = S_LOW;
        end else begin
          hi_cnt_d = sat_inc(hi_cnt_q);
        end
      end
      S_LOW: begin
        if (rise) begin
          valid_d       = 1'b1;
          pulse_width_d = hi_cnt_q;
          period_d      = per_cnt_q;
          range_err_d   = (hi_cnt_q < MIN_W) | (hi_cnt_q > MAX_W);
          no_signal_d   = 1'b0;
          hi_cnt_d      = 20'd1;
          per_cnt_d     = 20'd1;
          state_d       = S_HIGH;
        end else begin
          per_cnt_d = sat_inc(per_cnt_q);
        end
      end
      default: state_d = S_ARM;
    endcase

    // A silent line drops the partial frame; a stuck-high line must re-arm
    // so the next published frame starts from a clean rise.
    if (timeout) begin
      no_signal_d = 1'b1;
      to_cnt_d    = '0;
      hi_cnt_d    = '0;
      per_cnt_d   = '0;
      state_d     = s ? S_ARM : S_WAIT_RISE;
    end
  end

  assign bus.pulse_width = pulse_width_q;
  assign bus.period      = period_q;
  assign bus.valid       = valid_q;
  assign bus.range_err   = range_err_q;
  assign bus.no_signal   = no_signal_q;

endmodule
